player_input: RTL and testbench

PLAYER_INPUT -- requirements
Module: player_input

---
 rtl/player_input.sv | 138 +++++++++++++
 tb/tb_player_input.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/player_input.sv
// ---------------------------------------------------------------------------
// player_input : 16-channel switch synchronizer/debouncer, press pulses, lockout
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module player_input #(
   parameter int TICK_DIV      = 100000,
   parameter int STABLE_N      = 4,
   parameter int LOCKOUT_TICKS = 200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] raw_sw,
   output logic [15:0] player,
   output logic [15:0] press,
   output logic        lockout,
   output logic        tick
);

   localparam int              TW          = $clog2(TICK_DIV);
   localparam logic [TW-1:0]   TICK_LAST   = TW'(TICK_DIV - 1);
   localparam logic [3:0]      STABLE_LAST = 4'(STABLE_N);
   localparam logic [15:0]     LOCK_LOAD   = 16'(LOCKOUT_TICKS);
   localparam bit              LOCK_EN     = (LOCKOUT_TICKS != 0);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } lock_state_t;

   logic [15:0]   sync1;
   logic [15:0]   sync2;
   logic [TW-1:0] tick_cnt;
   logic [TW-1:0] tick_cnt_next;
   logic [3:0]    cnt      [16];
   logic [3:0]    cnt_next [16];
   logic [15:0]   qualify;
   logic [15:0]   player_next;
   logic [15:0]   rise;
   lock_state_t   state;
   lock_state_t   state_next;
   logic [15:0]   lock_cnt;
   logic [15:0]   lock_cnt_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw_sw;
         sync2 <= sync1;
      end
   end

   // tick is registered from the next count so it lines up with TICK_LAST
   assign tick_cnt_next = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
         tick     <= 1'b0;
      end else begin
         tick_cnt <= tick_cnt_next;
         tick     <= (tick_cnt_next == TICK_LAST);
      end
   end

   for (genvar i = 0; i < 16; i++) begin : g_bit
      logic [3:0] cnt_inc;
      assign cnt_inc        = cnt[i] + 4'd1;
      assign qualify[i]     = tick && (sync2[i] != player[i]) && (cnt_inc == STABLE_LAST);
      assign player_next[i] = qualify[i] ? sync2[i] : player[i];
      assign rise[i]        = qualify[i] && sync2[i];
      assign cnt_next[i]    = !tick                                 ? cnt[i] :
                              ((sync2[i] == player[i]) || qualify[i]) ? 4'd0   :
                                                                       cnt_inc;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         player <= '0;
         press  <= '0;
         for (int i = 0; i < 16; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         player <= player_next;
         press  <= lockout ? 16'h0000 : rise;
         for (int i = 0; i < 16; i++) begin
            cnt[i] <= cnt_next[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         lock_cnt <= '0;
         lockout  <= 1'b0;
      end else begin
         state    <= state_next;
         lock_cnt <= lock_cnt_next;
         lockout  <= (state_next == LOCKED);
      end
   end

   // The emitted press register starts the lockout, so lockout rises one cycle after it
   always_comb begin
      state_next    = state;
      lock_cnt_next = lock_cnt;
      case (state)
         IDLE: begin
            if (LOCK_EN && (press != 16'h0000)) begin
               state_next    = LOCKED;
               lock_cnt_next = LOCK_LOAD;
            end
         end
         LOCKED: begin
            if (tick) begin
               if (lock_cnt <= 16'd1) begin
                  state_next    = IDLE;
                  lock_cnt_next = 16'd0;
               end else begin
                  lock_cnt_next = lock_cnt - 16'd1;
               end
            end
         end
         default: begin
            state_next    = IDLE;
            lock_cnt_next = 16'd0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_player_input.sv
// ---------------------------------------------------------------------------
// tb_player_input : directed bench with press scoreboard for player_input
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_player_input;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] raw_sw = 16'h0000;
   logic [15:0] player;
   logic [15:0] press;
   logic        lockout;
   logic        tick;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_q[$];
   logic [15:0] prev_press = 16'h0000;

   player_input #(
      .TICK_DIV     (4),
      .STABLE_N     (3),
      .LOCKOUT_TICKS(2)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .raw_sw (raw_sw),
      .player (player),
      .press  (press),
      .lockout(lockout),
      .tick   (tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Every press pulse must match the next queued expectation and never repeat
   always @(negedge clk) begin
      if (press !== 16'h0000) begin
         if (exp_q.size() == 0) check("unexpected_press", press, 16'h0000);
         else                   check("press_sb", press, exp_q.pop_front());
         check("press_consecutive", prev_press, 16'h0000);
      end
      prev_press <= press;
   end

   // Returns at the negedge just after the next tick edge (counter back at 0)
   task automatic after_tick();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tick && n < 20);
      if (!tick) check("tick_timeout", 16'(tick), 16'h0001);
      @(negedge clk);
   endtask

   task automatic ticks(input int k);
      repeat (k) after_tick();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_player",  player,       16'h0000);
      check("rst_press",   press,        16'h0000);
      check("rst_lockout", 16'(lockout), 16'h0000);
      check("rst_tick",    16'(tick),    16'h0000);

      reset = 1'b1;
      @(negedge clk); check("tick_c1",    16'(tick), 16'h0000);
      @(negedge clk); check("tick_c2",    16'(tick), 16'h0000);
      @(negedge clk); check("first_tick", 16'(tick), 16'h0001);
      @(negedge clk); check("tick_c4",    16'(tick), 16'h0000);

      // clean press on bit 0
      raw_sw[0] = 1'b1;
      exp_q.push_back(16'h0001);
      ticks(2); check("clean_wait_player", player, 16'h0000);
      ticks(1);
      check("clean_player",  player,       16'h0001);
      check("clean_press",   press,        16'h0001);
      check("clean_lock_0",  16'(lockout), 16'h0000);
      @(negedge clk);
      check("clean_press_1cyc", press,        16'h0000);
      check("clean_lock_on",    16'(lockout), 16'h0001);
      ticks(1); check("clean_lock_t1",  16'(lockout), 16'h0001);
      ticks(1); check("clean_lock_end", 16'(lockout), 16'h0000);

      // bounce on bit 5
      raw_sw[5] = 1'b1; ticks(1);
      raw_sw[5] = 1'b0; ticks(1);
      raw_sw[5] = 1'b1;
      exp_q.push_back(16'h0020);
      ticks(2); check("bounce_wait_player", player, 16'h0001);
      ticks(1);
      check("bounce_player", player, 16'h0021);
      check("bounce_press",  press,  16'h0020);
      ticks(2); check("bounce_lock_end", 16'(lockout), 16'h0000);

      // release bit 0
      raw_sw[0] = 1'b0;
      ticks(2); check("release_wait_player", player, 16'h0021);
      ticks(1);
      check("release_player", player,       16'h0020);
      check("release_press",  press,        16'h0000);
      check("release_lock",   16'(lockout), 16'h0000);

      // suppression: bit 1 qualifies one tick after bit 0
      raw_sw[0] = 1'b1;
      exp_q.push_back(16'h0001);
      ticks(1);
      raw_sw[1] = 1'b1;
      ticks(2);
      check("supp_press0",  press,  16'h0001);
      check("supp_player0", player, 16'h0021);
      ticks(1);
      check("supp_player1", player,       16'h0023);
      check("supp_press1",  press,        16'h0000);
      check("supp_lock_on", 16'(lockout), 16'h0001);
      ticks(1); check("supp_lock_end", 16'(lockout), 16'h0000);
      raw_sw[2] = 1'b1;
      exp_q.push_back(16'h0004);
      ticks(3);
      check("supp_press2",  press,  16'h0004);
      check("supp_player2", player, 16'h0027);
      ticks(2); check("supp_lock_end2", 16'(lockout), 16'h0000);

      // simultaneous press of bits 15 and 0
      raw_sw = 16'h0000;
      ticks(3); check("sim_clear_player", player, 16'h0000);
      raw_sw = 16'h8001;
      exp_q.push_back(16'h8001);
      ticks(3);
      check("sim_press",  press,  16'h8001);
      check("sim_player", player, 16'h8001);
      @(negedge clk); check("sim_lock_on", 16'(lockout), 16'h0001);
      ticks(1); check("sim_lock_t1",  16'(lockout), 16'h0001);
      ticks(1); check("sim_lock_end", 16'(lockout), 16'h0000);

      // reset during lockout with bit 1 mid-qualification
      raw_sw = 16'h0000;
      ticks(3); check("mr_clear_player", player, 16'h0000);
      raw_sw = 16'h0001;
      exp_q.push_back(16'h0001);
      ticks(3); check("mr_press0", press, 16'h0001);
      raw_sw = 16'h0003;
      ticks(1); check("mr_locked", 16'(lockout), 16'h0001);
      #2 reset = 1'b0;
      #1;
      check("mr_player",  player,       16'h0000);
      check("mr_press",   press,        16'h0000);
      check("mr_lockout", 16'(lockout), 16'h0000);
      check("mr_tick",    16'(tick),    16'h0000);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      exp_q.push_back(16'h0003);
      ticks(2); check("mr_wait_player", player, 16'h0000);
      ticks(1);
      check("mr_requal_press",  press,  16'h0003);
      check("mr_requal_player", player, 16'h0003);
      ticks(2); check("mr_lock_end", 16'(lockout), 16'h0000);

      repeat (2) @(negedge clk);
      check("queue_empty", 16'(exp_q.size()), 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
